// File: rtl/pes_gray_codec.sv
// Pipelined binary<->Gray codec with per-word mode and valid/ready flow control.
// Optional Gray-step checker on decode words is enabled by defining PES_GRAY_STEP_CHECK_EN.
module pes_gray_codec #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step_err
);

  // Handshake: a word moves across a port on a rising edge where valid && ready;
  // a held output word keeps data/mode/err stable until it is taken.

  localparam int SLICE = (WIDTH + PIPE - 1) / PIPE;

  if (PIPE < 1 || PIPE > 4 || WIDTH < 2 || WIDTH > 64 || PIPE > WIDTH) begin : g_bad_params
    $error("pes_gray_codec: illegal WIDTH/PIPE combination");
  end

  logic in_err;

`ifdef PES_GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] hist_q;
  logic             hist_valid_q;
  logic [6:0]       diff_ones;

  // A legal Gray step changes exactly one bit; a repeat (zero bits) is also flagged.
  always_comb begin
    diff_ones = 7'd0;
    for (int i = 0; i < WIDTH; i++) begin
      diff_ones = diff_ones + {6'd0, in_data[i] ^ hist_q[i]};
    end
    in_err = in_mode && hist_valid_q && (diff_ones != 7'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
    end else if (in_valid && in_ready && in_mode) begin
      hist_q       <= in_data;
      hist_valid_q <= 1'b1;
    end
  end
`else
  assign in_err = 1'b0;
`endif

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    // Decode slice owned by this stage, MSB slice first; may be empty at odd widths.
    localparam int HI = WIDTH - 1 - k * SLICE;
    localparam int LO = (WIDTH - (k + 1) * SLICE > 0) ? WIDTH - (k + 1) * SLICE : 0;

    logic             valid_q;
    logic             mode_q;
    logic             err_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load;
    logic             take;
    logic             carry;
    logic             src_valid;
    logic             src_mode;
    logic             src_err;
    logic [WIDTH-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_mode  = in_mode;
      assign src_err   = in_err;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = g_stage[k-1].valid_q;
      assign src_mode  = g_stage[k-1].mode_q;
      assign src_err   = g_stage[k-1].err_q;
      assign src_data  = g_stage[k-1].data_q;
    end

    if (k == PIPE - 1) begin : g_tail
      assign take = out_ready;
    end else begin : g_mid
      assign take = g_stage[k+1].load;
    end

    assign load = !valid_q || take;

    // Bits above HI are already binary, so carry tracks b[i+1] while walking down.
    always_comb begin
      data_d = src_data;
      carry  = 1'b0;
      if (src_mode) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (i <= HI && i >= LO) begin
            data_d[i] = carry ^ src_data[i];
          end
          carry = data_d[i];
        end
      end else if (k == 0) begin
        data_d = src_data ^ (src_data >> 1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        mode_q  <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end else if (load) begin
        valid_q <= src_valid;
        if (src_valid) begin
          data_q <= data_d;
          mode_q <= src_mode;
          err_q  <= src_err;
        end
      end
    end
  end

  assign in_ready     = g_stage[0].load;
  assign out_valid    = g_stage[PIPE-1].valid_q;
  assign out_data     = g_stage[PIPE-1].data_q;
  assign out_mode     = g_stage[PIPE-1].mode_q;
  assign out_step_err = g_stage[PIPE-1].err_q;

endmodule

// File: tb/tb_pes_gray_codec.sv
// Bench for pes_gray_codec: a WIDTH=4/PIPE=2 instance driven from a vector table and
// hand sequences, and a WIDTH=13/PIPE=4 instance driven with random mixed traffic.
module tb_pes_gray_codec;

  localparam int W_A = 4;
  localparam int P_A = 2;
  localparam int W_B = 13;
  localparam int P_B = 4;
`ifdef PES_GRAY_STEP_CHECK_EN
  localparam logic STEP_ON = 1'b1;
`else
  localparam logic STEP_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic a_rst_req = 1'b1;
  logic b_rst_req = 1'b1;

  logic           a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
  logic [W_A-1:0] a_in_data = '0, a_out_data;
  logic           a_out_valid, a_out_ready = 1'b1, a_out_mode, a_out_err;

  logic           b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
  logic [W_B-1:0] b_in_data = '0, b_out_data;
  logic           b_out_valid, b_out_ready = 1'b1, b_out_mode, b_out_err;

  pes_gray_codec #(.WIDTH(W_A), .PIPE(P_A)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_mode(a_out_mode), .out_step_err(a_out_err)
  );

  pes_gray_codec #(.WIDTH(W_B), .PIPE(P_B)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_mode(b_out_mode), .out_step_err(b_out_err)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W_A-1:0] a_exp_q[$];
  logic           a_mode_q[$];
  logic           a_err_q[$];
  int             a_cyc_q[$];
  int             a_last_stall = -1;

  logic [W_B-1:0] b_exp_q[$];
  logic           b_mode_q[$];
  logic           b_err_q[$];
  int             b_cyc_q[$];
  int             b_last_stall = -1;
  logic           b_rnd_ready = 1'b0;

  // reference history for the random stream
  logic [W_B-1:0] hb = '0;
  logic           hb_v = 1'b0;

  typedef struct {
    logic [3:0] din;
    logic       mode;
    logic [3:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_enc(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  // binary bit i is the parity of all Gray bits at or above i
  function automatic logic [63:0] ref_dec(input logic [63:0] g);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 64; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // ---------------- driver tasks: instance A ----------------
  task automatic cyc_a(input logic v, input logic [W_A-1:0] d, input logic m, input logic ordy,
                       input logic [W_A-1:0] ed, input logic ee, output logic fired);
    @(negedge clk);
    rst_a       = a_rst_req;
    a_in_valid  = v;
    a_in_data   = d;
    a_in_mode   = m;
    a_out_ready = ordy;
    #1;
    fired = 1'b0;
    if (rst_a) begin
      a_exp_q.delete(); a_mode_q.delete(); a_err_q.delete(); a_cyc_q.delete();
      a_last_stall = -1;
    end else begin
      if (a_out_valid) begin
        if (a_exp_q.size() == 0) begin
          chk("a_unexpected_out", 64'(a_out_valid), 64'(0));
        end else begin
          chk("a_data", 64'(a_out_data), 64'(a_exp_q[0]));
          chk("a_mode", 64'(a_out_mode), 64'(a_mode_q[0]));
          chk("a_err", 64'(a_out_err), 64'(a_err_q[0]));
          if (ordy) begin
            if (a_last_stall <= a_cyc_q[0]) chk("a_latency", 64'(cyc - a_cyc_q[0]), 64'(P_A));
            void'(a_exp_q.pop_front()); void'(a_mode_q.pop_front());
            void'(a_err_q.pop_front()); void'(a_cyc_q.pop_front());
          end
        end
      end
      if (!ordy) a_last_stall = cyc;
      fired = v && a_in_ready;
      if (fired) begin
        a_exp_q.push_back(ed); a_mode_q.push_back(m); a_err_q.push_back(ee); a_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  task automatic idle_a(input int n);
    logic f;
    repeat (n) cyc_a(1'b0, '0, 1'b0, 1'b1, '0, 1'b0, f);
  endtask

  task automatic send_a(input logic [W_A-1:0] d, input logic m, input logic [W_A-1:0] ed, input logic ee);
    logic f;
    f = 1'b0;
    for (int t = 0; t < 64 && !f; t++) cyc_a(1'b1, d, m, 1'b1, ed, ee, f);
    chk("a_accept", 64'(f), 64'(1));
  endtask

  task automatic drain_a();
    logic f;
    for (int t = 0; t < 100 && a_exp_q.size() != 0; t++) cyc_a(1'b0, '0, 1'b0, 1'b1, '0, 1'b0, f);
    chk("a_drain", 64'(a_exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_out_valid"}, 64'(a_out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(a_out_data), 64'(0));
    chk({tag, "_out_mode"}, 64'(a_out_mode), 64'(0));
    chk({tag, "_out_err"}, 64'(a_out_err), 64'(0));
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'(1));
  endtask

  // ---------------- driver tasks: instance B ----------------
  task automatic cyc_b(input logic v, input logic [W_B-1:0] d, input logic m, input logic ordy,
                       input logic [W_B-1:0] ed, input logic ee, output logic fired);
    @(negedge clk);
    rst_b       = b_rst_req;
    b_in_valid  = v;
    b_in_data   = d;
    b_in_mode   = m;
    b_out_ready = ordy;
    #1;
    fired = 1'b0;
    if (rst_b) begin
      b_exp_q.delete(); b_mode_q.delete(); b_err_q.delete(); b_cyc_q.delete();
      b_last_stall = -1;
    end else begin
      if (b_out_valid) begin
        if (b_exp_q.size() == 0) begin
          chk("b_unexpected_out", 64'(b_out_valid), 64'(0));
        end else begin
          chk("b_data", 64'(b_out_data), 64'(b_exp_q[0]));
          chk("b_mode", 64'(b_out_mode), 64'(b_mode_q[0]));
          chk("b_err", 64'(b_out_err), 64'(b_err_q[0]));
          if (ordy) begin
            if (b_last_stall <= b_cyc_q[0]) chk("b_latency", 64'(cyc - b_cyc_q[0]), 64'(P_B));
            void'(b_exp_q.pop_front()); void'(b_mode_q.pop_front());
            void'(b_err_q.pop_front()); void'(b_cyc_q.pop_front());
          end
        end
      end
      if (!ordy) b_last_stall = cyc;
      fired = v && b_in_ready;
      if (fired) begin
        b_exp_q.push_back(ed); b_mode_q.push_back(m); b_err_q.push_back(ee); b_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  function automatic logic pick_ready_b();
    return b_rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic idle_b(input int n);
    logic f;
    repeat (n) cyc_b(1'b0, '0, 1'b0, pick_ready_b(), '0, 1'b0, f);
  endtask

  task automatic send_rand_b();
    logic [W_B-1:0] d, ed;
    logic           m, ee, f;
    int             sel;
    m   = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 7);
    if (sel == 0)      d = hb;
    else if (sel <= 2) d = hb ^ (W_B'(1) << $urandom_range(0, W_B - 1));
    else               d = W_B'($urandom);
    if (m) begin
      ed = W_B'(ref_dec(64'(d)));
      ee = STEP_ON && hb_v && ($countones(d ^ hb) != 1);
    end else begin
      ed = W_B'(ref_enc(64'(d)));
      ee = 1'b0;
    end
    f = 1'b0;
    for (int t = 0; t < 64 && !f; t++) cyc_b(1'b1, d, m, pick_ready_b(), ed, ee, f);
    chk("b_accept", 64'(f), 64'(1));
    if (f && m) begin
      hb   = d;
      hb_v = 1'b1;
    end
  endtask

  task automatic drain_b();
    logic f;
    for (int t = 0; t < 500 && b_exp_q.size() != 0; t++) cyc_b(1'b0, '0, 1'b0, pick_ready_b(), '0, 1'b0, f);
    chk("b_drain", 64'(b_exp_q.size()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic f;
    int   n, c0;

    vecs[0]  = '{4'b0101, 1'b0, 4'b0111, 1'b0};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
    vecs[3]  = '{4'b1000, 1'b0, 4'b1100, 1'b0};
    vecs[4]  = '{4'b0011, 1'b1, 4'b0010, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, STEP_ON};
    vecs[6]  = '{4'b1101, 1'b1, 4'b1001, STEP_ON};
    vecs[7]  = '{4'b1000, 1'b0, 4'b1100, 1'b0};
    vecs[8]  = '{4'b1000, 1'b1, 4'b1111, STEP_ON};
    vecs[9]  = '{4'b1000, 1'b1, 4'b1111, STEP_ON};
    vecs[10] = '{4'b1001, 1'b1, 4'b1110, 1'b0};
    vecs[11] = '{4'b1111, 1'b0, 4'b1000, 1'b0};

    // power-on reset of A
    a_rst_req = 1'b1;
    idle_a(3);
    a_rst_req = 1'b0;
    idle_a(1);
    chk_reset_a("reset");

    // table vectors back-to-back
    for (int i = 0; i < 12; i++) send_a(vecs[i].din, vecs[i].mode, vecs[i].exp_data, vecs[i].exp_err);
    drain_a();

    // encode sweep, one accept per cycle
    c0 = cyc;
    for (int v = 0; v < 16; v++) send_a(4'(v), 1'b0, 4'(ref_enc(64'(v))), 1'b0);
    chk("a_sweep_rate", 64'(cyc - c0), 64'(16));
    drain_a();

    // backpressure: capacity PIPE, then ready returns in the same cycle
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b1, 4'(i + 3), 1'b0, 1'b0, 4'(ref_enc(64'(i + 3))), 1'b0, f);
      if (f) n++;
    end
    chk("a_capacity", 64'(n), 64'(P_A));
    chk("a_full_in_ready", 64'(a_in_ready), 64'(0));
    cyc_a(1'b1, 4'hA, 1'b0, 1'b1, 4'(ref_enc(64'hA)), 1'b0, f);
    chk("a_ready_returns", 64'(a_in_ready), 64'(1));
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b1, 4'(i * 5), 1'b1, 1'b1, 4'(ref_dec(64'(4'(i * 5)))), 1'b0, f);
      if (f) n++;
    end
    chk("a_full_rate", 64'(n), 64'(8));
    drain_a();

    // reset with two decode words in flight; neither may appear, history cleared
    cyc_a(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0010, 1'b0, f);
    cyc_a(1'b1, 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b0, f);
    a_rst_req = 1'b1;
    idle_a(3);
    a_rst_req = 1'b0;
    idle_a(1);
    chk_reset_a("mreset");
    idle_a(6);
    send_a(4'b0110, 1'b1, 4'b0100, 1'b0);
    drain_a();

    // instance B: random mixed-mode traffic
    b_rst_req = 1'b1;
    idle_b(3);
    b_rst_req = 1'b0;
    hb_v = 1'b0;
    hb   = '0;
    idle_b(1);
    chk("b_reset_out_valid", 64'(b_out_valid), 64'(0));
    chk("b_reset_in_ready", 64'(b_in_ready), 64'(1));
    b_rnd_ready = 1'b0;
    for (int i = 0; i < 150; i++) begin
      idle_b($urandom_range(0, 1));
      send_rand_b();
    end
    b_rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_b(1);
      send_rand_b();
    end
    drain_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
